// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Default widths, the hard-wired zero register index, and requester indices.
// No logic; imported by the top and its holding-buffer sub-module.
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 reads as zero; writes to it are consumed but never strobed.
  localparam int ZERO_REG = 0;

  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_idx_t;

endpackage

// File: rtl/regfile_write_arbiter_hold_buffer.sv
// wb_hold_buffer: one-entry writeback holding slot (valid/addr/data).
// Latency: load or clear takes effect at the next rising edge of clk.
// Backpressure: none internally; the owner decides when load/clear assert.
// Ports: clk, reset (sync, active-high), load + load_addr/load_data, clear,
//        valid/addr/data reflecting the held entry.
module wb_hold_buffer
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // A load on the same edge as a clear wins: the slot is drained and
  // refilled back-to-back, which is what keeps a lone requester at full rate.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= load_addr;
      data  <= load_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (0)
// and load/multi-cycle (1) writeback. Latency: accept N -> buffered N+1 ->
// wr_enable N+2. Backpressure: reqN_ready is low only while bufferN is full
// and not being granted this cycle (and during reset).
// Ports: reqN_valid/ready/addr/data per requester; registered wr_enable,
//        wr_addr, wr_data, wr_src to the register file; rd_addr -> rd_pending
//        for the decode interlock.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_src,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_pending
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              buf0_valid, buf1_valid;
  logic [ADDR_W-1:0] buf0_addr, buf1_addr;
  logic [DATA_W-1:0] buf0_data, buf1_data;

  logic              grant0, grant1, grant_any;
  logic [ADDR_W-1:0] granted_addr;
  logic [DATA_W-1:0] granted_data;
  logic              granted_src;
  logic              load0, load1;
  req_idx_t          last_grant;

  // Holding slots
  wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .load_addr (req0_addr),
    .load_data (req0_data),
    .clear     (grant0),
    .valid     (buf0_valid),
    .addr      (buf0_addr),
    .data      (buf0_data)
  );

  wb_hold_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .load_addr (req1_addr),
    .load_data (req1_data),
    .clear     (grant1),
    .valid     (buf1_valid),
    .addr      (buf1_addr),
    .data      (buf1_data)
  );

  // Arbitration: on a tie the requester that did not win last time goes.
  always_comb begin
    grant0 = buf0_valid && (!buf1_valid || (last_grant == REQ_LOAD));
    grant1 = buf1_valid && (!buf0_valid || (last_grant == REQ_ALU));
    grant_any = grant0 || grant1;
    granted_addr = grant1 ? buf1_addr : buf0_addr;
    granted_data = grant1 ? buf1_data : buf0_data;
    granted_src  = grant1;
  end

  // Ready looks through a slot that is being drained this cycle.
  assign req0_ready = !reset && (!buf0_valid || grant0);
  assign req1_ready = !reset && (!buf1_valid || grant1);
  assign load0      = req0_valid && req0_ready;
  assign load1      = req1_valid && req1_ready;

  // Starting at REQ_LOAD makes requester 0 win the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= REQ_LOAD;
    end else if (grant_any) begin
      last_grant <= grant1 ? REQ_LOAD : REQ_ALU;
    end
  end

  // Registered write port. Register-0 beats are consumed without a strobe;
  // addr/data/src still follow the grant so the bus shows what was drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_src    <= 1'b0;
    end else if (grant_any) begin
      wr_enable <= (granted_addr != ZERO_ADDR);
      wr_addr   <= granted_addr;
      wr_data   <= granted_data;
      wr_src    <= granted_src;
    end else begin
      wr_enable <= 1'b0;
    end
  end

  // Decode interlock: any write still in a buffer or on the port this cycle.
  always_comb begin
    rd_pending = 1'b0;
    if (rd_addr != ZERO_ADDR) begin
      rd_pending = (buf0_valid && (buf0_addr == rd_addr)) ||
                   (buf1_valid && (buf1_addr == rd_addr)) ||
                   (wr_enable  && (wr_addr   == rd_addr));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr, req1_addr, rd_addr, wr_addr;
  logic [DW-1:0] req0_data, req1_data, wr_data;
  logic          wr_enable, wr_src, rd_pending;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .wr_enable  (wr_enable),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_src     (wr_src),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } item_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            src;
    int            cyc;
  } beat_t;

  item_t src0_q[$];
  item_t src1_q[$];
  beat_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  // Reference state: what each requester has parked, who won last, and
  // what the write port should be showing.
  bit            m_occ[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_data[2];
  int            m_last;
  bit            m_we;
  logic [AW-1:0] m_wa;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every strobed beat must be the next expected write, on time.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc && wr_enable !== 1'b1) begin
      check("missing_write", {63'd0, wr_enable}, 64'd1);
      void'(exp_q.pop_front());
    end else if (wr_enable === 1'b1) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        check("spurious_write", 64'd1, 64'd0);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("wr_addr", {59'd0, wr_addr}, {59'd0, b.addr});
        check("wr_data", {32'd0, wr_data}, {32'd0, b.data});
        check("wr_src",  {63'd0, wr_src},  {63'd0, b.src});
      end
    end
  end

  // One clock of stimulus. Called just after a rising edge; leaves just
  // after the next one. offN gates whether requester N presents its head item.
  task automatic step(input bit rst, input logic [AW-1:0] rd, input bit off0, input bit off1);
    bit            v[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];
    bit            rdy[2];
    int            g;
    bit            pend;
    v[0] = off0 && (src0_q.size() > 0);
    v[1] = off1 && (src1_q.size() > 0);
    if (v[0]) begin a[0] = src0_q[0].addr; d[0] = src0_q[0].data; end
    else begin a[0] = AW'($urandom); d[0] = $urandom; end
    if (v[1]) begin a[1] = src1_q[0].addr; d[1] = src1_q[0].data; end
    else begin a[1] = AW'($urandom); d[1] = $urandom; end
    reset = rst;
    req0_valid = v[0]; req0_addr = a[0]; req0_data = d[0];
    req1_valid = v[1]; req1_addr = a[1]; req1_data = d[1];
    rd_addr = rd;
    #1;
    // Who drains this cycle: a lone parked entry, or on a tie the one
    // that did not win last time.
    if (m_occ[0] && m_occ[1]) g = (m_last == 0) ? 1 : 0;
    else if (m_occ[0])        g = 0;
    else if (m_occ[1])        g = 1;
    else                      g = -1;
    for (int i = 0; i < 2; i++) rdy[i] = !rst && (!m_occ[i] || g == i);
    pend = (rd != 0) && ((m_occ[0] && m_addr[0] == rd) ||
                         (m_occ[1] && m_addr[1] == rd) ||
                         (m_we && m_wa == rd));
    check("req0_ready", {63'd0, req0_ready}, {63'd0, rdy[0]});
    check("req1_ready", {63'd0, req1_ready}, {63'd0, rdy[1]});
    check("rd_pending", {63'd0, rd_pending}, {63'd0, pend});
    check("wr_enable",  {63'd0, wr_enable},  {63'd0, m_we});
    check("wr_addr_hold", {59'd0, wr_addr}, {59'd0, m_wa});
    if (rst) begin
      m_occ[0] = 0; m_occ[1] = 0; m_last = 1; m_we = 0; m_wa = '0;
    end else begin
      m_we = 0;
      if (g >= 0) begin
        if (m_addr[g] != 0) exp_q.push_back('{m_addr[g], m_data[g], g[0], cyc + 1});
        m_we = (m_addr[g] != 0);
        m_wa = m_addr[g];
        m_last = g;
        m_occ[g] = 0;
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i] && rdy[i]) begin
          m_occ[i] = 1; m_addr[i] = a[i]; m_data[i] = d[i];
        end
      end
      if (v[0] && rdy[0]) void'(src0_q.pop_front());
      if (v[1] && rdy[1]) void'(src1_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_occ[0] = 0; m_occ[1] = 0; m_last = 1; m_we = 0; m_wa = '0;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
    rd_addr = '0;
    @(posedge clk); #1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_wr_enable", {63'd0, wr_enable}, 64'd0);
    check("rst_wr_addr",   {59'd0, wr_addr},   64'd0);
    check("rst_wr_data",   {32'd0, wr_data},   64'd0);
    check("rst_wr_src",    {63'd0, wr_src},    64'd0);

    // Single write, two-cycle latency, rd_addr watching r5.
    src0_q.push_back('{5'd5, 32'hDEADBEEF});
    repeat (5) step(0, 5, 1, 1);

    // Contention: strict alternation, per-requester order preserved.
    for (int i = 0; i < 6; i++) begin
      src0_q.push_back('{5'd1, 32'hA0 + i});
      src1_q.push_back('{5'd2, 32'hB0 + i});
    end
    repeat (15) step(0, 2, 1, 1);

    // Register 0: consumed, never strobed, never pending.
    src1_q.push_back('{5'd0, 32'h1234});
    repeat (4) step(0, 0, 1, 1);

    // Streaming: one requester, eight back-to-back writes.
    for (int i = 1; i <= 8; i++) src0_q.push_back('{AW'(i), 32'h1000 + i});
    repeat (12) step(0, 3, 1, 1);

    // Pending interlock on r7.
    src1_q.push_back('{5'd7, 32'h77});
    repeat (5) step(0, 7, 1, 1);

    // Reset with both slots full, then a fresh tie goes to requester 0.
    src0_q.push_back('{5'd9,  32'h9});
    src1_q.push_back('{5'd10, 32'hA});
    step(0, 9, 1, 1);
    step(1, 9, 1, 1);
    src0_q.push_back('{5'd11, 32'hB});
    src1_q.push_back('{5'd12, 32'hC});
    repeat (5) step(0, 11, 1, 1);

    // Randomized traffic with gaps, shared addresses and rare resets.
    for (int n = 0; n < 400; n++) begin
      if (($urandom % 3) != 0 && src0_q.size() < 4)
        src0_q.push_back('{AW'($urandom % 8), $urandom});
      if (($urandom % 3) != 0 && src1_q.size() < 4)
        src1_q.push_back('{AW'($urandom % 8), $urandom});
      step(($urandom % 97) == 0, AW'($urandom % 8),
           ($urandom % 4) != 0, ($urandom % 4) != 0);
    end
    src0_q.delete();
    src1_q.delete();
    repeat (6) step(0, 0, 0, 0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
